pwm_capture: RTL and testbench

//  Measures an incoming PWM/tach signal: period and high time, in clk ticks.

---
 rtl/pwm_capture_pkg.sv | 30 +++
 rtl/pwm_capture_if.sv | 24 ++
 rtl/pwm_capture_sync.sv | 35 +++
 rtl/pwm_capture.sv | 195 +++++++++++++++++++
 tb/tb_pwm_capture.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg
//   Shared types and constants for the PWM/tach capture block:
//   FSM state encoding, Avalon register word addresses, status and
//   control bit positions.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2,
        LOW       = 2'd3
    } state_t;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_PERIOD  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_HIGH    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_COUNT   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_TIMEOUT = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_CONTROL = 3'd5;

    localparam int STAT_VALID   = 0;
    localparam int STAT_TIMEOUT = 1;
    localparam int STAT_STUCK   = 2;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_CLEAR  = 1;

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if
//   Avalon-MM slave bus of the capture block.
//   address/write/writedata/read : master -> slave
//   readdata/waitrequest         : slave -> master
interface pwm_capture_if;
    import pwm_capture_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              write;
    logic [31:0]       writedata;
    logic              read;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (
        output address, write, writedata, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, waitrequest
    );
endinterface

// File: rtl/pwm_capture_sync.sv
// pwm_in_sync
//   Brings the asynchronous pwm_in into the clk domain and detects edges.
//   clk, reset : system clock, synchronous active-high reset
//   pwm_in     : asynchronous input
//   level      : synchronised level
//   rise, fall : one-cycle pulses on synchronised edges
module pwm_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures period (rise to rise) and high time (rise to fall) of a
//   PWM/tach input in clk ticks; results on ports and over Avalon-MM.
//   clk, reset      : system clock, synchronous active-high reset
//   avs             : Avalon-MM slave (one read wait state, zero-wait writes)
//   pwm_in          : asynchronous PWM/tach input
//   period_ticks    : last measured period
//   high_ticks      : last measured high time
//   valid           : period_ticks/high_ticks hold a complete measurement
//
//   state     | meaning
//   IDLE      | disabled, counter held at 0, edges ignored
//   WAIT_RISE | waiting for a rise to start a measurement
//   HIGH      | input high, waiting for fall to latch high time
//   LOW       | input low, next rise publishes period/high
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED_HZ = 50_000_000,
    parameter int unsigned TIMEOUT_TICKS  = CLOCK_SPEED_HZ / 10,
    parameter int          SYNC_STAGES    = 2
) (
    input  logic          clk,
    input  logic          reset,
    pwm_capture_if.slave  avs,
    input  logic          pwm_in,
    output logic [31:0]   period_ticks,
    output logic [31:0]   high_ticks,
    output logic          valid
);

    localparam logic [31:0] TIMEOUT_INIT = 32'(TIMEOUT_TICKS);

    logic        sync_level, sync_rise, sync_fall;
    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0] hi_latch_q, hi_latch_d;
    logic [31:0] period_d, high_d;
    logic        valid_d;
    logic        timeout_q, timeout_d;
    logic        stuck_q, stuck_d;
    logic [31:0] count_q, count_d;
    logic [31:0] timeout_reg_q;
    logic        enable_q;
    logic        rd_done_q;
    logic [31:0] rd_data_q, rd_mux;
    logic        ctrl_wr, en_eff, clr, timeout_hit;

    pwm_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (pwm_in),
        .level  (sync_level),
        .rise   (sync_rise),
        .fall   (sync_fall)
    );

    // Control writes steer the FSM on the same edge that stores them, so
    // clear/disable are visible the cycle after the write like any register.
    assign ctrl_wr     = avs.write && (avs.address == ADDR_CONTROL);
    assign en_eff      = ctrl_wr ? avs.writedata[CTRL_ENABLE] : enable_q;
    assign clr         = ctrl_wr && avs.writedata[CTRL_CLEAR];
    assign timeout_hit = (timeout_reg_q != 32'd0) && (cnt_q >= timeout_reg_q);
    assign cnt_inc     = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_RISE;
            cnt_q        <= '0;
            hi_latch_q   <= '0;
            period_ticks <= '0;
            high_ticks   <= '0;
            valid        <= 1'b0;
            timeout_q    <= 1'b0;
            stuck_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_latch_q   <= hi_latch_d;
            period_ticks <= period_d;
            high_ticks   <= high_d;
            valid        <= valid_d;
            timeout_q    <= timeout_d;
            stuck_q      <= stuck_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc;
        hi_latch_d = hi_latch_q;
        period_d   = period_ticks;
        high_d     = high_ticks;
        valid_d    = valid;
        timeout_d  = timeout_q;
        stuck_d    = stuck_q;
        count_d    = count_q;
        if (clr) begin
            cnt_d      = '0;
            hi_latch_d = '0;
            period_d   = '0;
            high_d     = '0;
            valid_d    = 1'b0;
            timeout_d  = 1'b0;
            stuck_d    = 1'b0;
            count_d    = '0;
            state_d    = en_eff ? WAIT_RISE : IDLE;
        end else if (!en_eff) begin
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            cnt_d   = '0;
            state_d = WAIT_RISE;
        end else if (timeout_hit) begin
            // Counter restarts so WAIT_RISE can accept the next rise.
            cnt_d     = '0;
            period_d  = '0;
            high_d    = '0;
            valid_d   = 1'b0;
            timeout_d = 1'b1;
            stuck_d   = sync_level;
            state_d   = WAIT_RISE;
        end else begin
            case (state_q)
                WAIT_RISE: begin
                    if (sync_rise) begin
                        cnt_d   = 32'd1;
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    if (sync_fall) begin
                        hi_latch_d = cnt_q;
                        state_d    = LOW;
                    end
                end
                LOW: begin
                    if (sync_rise) begin
                        period_d  = cnt_q;
                        high_d    = hi_latch_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        count_d   = count_q + 32'd1;
                        cnt_d     = 32'd1;
                        state_d   = HIGH;
                    end
                end
                default: state_d = WAIT_RISE;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs.address)
            ADDR_PERIOD:  rd_mux = period_ticks;
            ADDR_HIGH:    rd_mux = high_ticks;
            ADDR_STATUS:  rd_mux = {29'd0, stuck_q, timeout_q, valid};
            ADDR_COUNT:   rd_mux = count_q;
            ADDR_TIMEOUT: rd_mux = timeout_reg_q;
            ADDR_CONTROL: rd_mux = {31'd0, enable_q};
            default:      rd_mux = '0;
        endcase
    end

    // Read data is captured in the wait-state cycle, so a read that lands on
    // a measurement update returns the value from before the update.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q      <= 1'b1;
            timeout_reg_q <= TIMEOUT_INIT;
            rd_done_q     <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            if (avs.write) begin
                case (avs.address)
                    ADDR_TIMEOUT: timeout_reg_q <= avs.writedata;
                    ADDR_CONTROL: enable_q      <= avs.writedata[CTRL_ENABLE];
                    default: ;
                endcase
            end
            rd_done_q <= avs.read && !rd_done_q;
            if (avs.read && !rd_done_q) begin
                rd_data_q <= rd_mux;
            end
        end
    end

    assign avs.readdata    = rd_data_q;
    assign avs.waitrequest = avs.read && !rd_done_q;

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;
    import pwm_capture_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pwm_in = 1'b0;
    logic [31:0] period_ticks, high_ticks;
    logic        valid;
    logic [31:0] rd;
    int          checks = 0;
    int          failures = 0;

    pwm_capture_if bus ();

    pwm_capture #(
        .CLOCK_SPEED_HZ (50_000_000),
        .TIMEOUT_TICKS  (5_000_000),
        .SYNC_STAGES    (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .avs          (bus),
        .pwm_in       (pwm_in),
        .period_ticks (period_ticks),
        .high_ticks   (high_ticks),
        .valid        (valid)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic avm_write(input logic [2:0] a, input logic [31:0] d);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        tick(1);
        bus.write     = 1'b0;
    endtask

    task automatic avm_read(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        bus.read    = 1'b1;
        #1;
        check("waitreq_first", 32'(bus.waitrequest), 32'd1);
        tick(1);
        check("waitreq_second", 32'(bus.waitrequest), 32'd0);
        d = bus.readdata;
        tick(1);
        bus.read = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        avm_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic pulse(input int hi, input int lo);
        pwm_in = 1'b1;
        tick(hi);
        pwm_in = 1'b0;
        tick(lo);
    endtask

    task automatic check_meas(input string tag, input logic [31:0] p, input logic [31:0] h, input logic v);
        check({tag, "_period"}, period_ticks, p);
        check({tag, "_high"}, high_ticks, h);
        check({tag, "_valid"}, 32'(valid), 32'(v));
    endtask

    initial begin
        bus.address   = '0;
        bus.write     = 1'b0;
        bus.writedata = '0;
        bus.read      = 1'b0;
        tick(3);
        reset = 1'b0;

        // 1: reset state and timeout register default
        check_meas("rst", 32'd0, 32'd0, 1'b0);
        read_check("rst_timeout", ADDR_TIMEOUT, 32'd5_000_000);
        read_check("rst_status", ADDR_STATUS, 32'd0);
        read_check("rst_control", ADDR_CONTROL, 32'd1);
        read_check("rst_unmapped", 3'd6, 32'd0);

        // 2: three 30/70 periods
        pulse(30, 70);
        pulse(30, 70);
        pulse(30, 70);
        check_meas("basic", 32'd100, 32'd30, 1'b1);
        read_check("basic_rd_period", ADDR_PERIOD, 32'd100);
        read_check("basic_rd_high", ADDR_HIGH, 32'd30);
        read_check("basic_status", ADDR_STATUS, 32'd1);
        read_check("basic_count", ADDR_COUNT, 32'd2);
        avm_write(ADDR_PERIOD, 32'hDEAD);
        read_check("ro_write_ignored", ADDR_PERIOD, 32'd100);

        // 3: timeout with input stuck high
        avm_write(ADDR_TIMEOUT, 32'd500);
        pwm_in = 1'b1;
        tick(502);
        check("pre_timeout_valid", 32'(valid), 32'd1);
        tick(1);
        check_meas("timeout", 32'd0, 32'd0, 1'b0);
        read_check("timeout_status", ADDR_STATUS, 32'b110);
        pwm_in = 1'b0;
        avm_write(ADDR_TIMEOUT, 32'd0);
        tick(10);

        // 4: clear coincident with a detected rise
        pwm_in = 1'b1;
        tick(2);
        avm_write(ADDR_CONTROL, 32'd3);
        read_check("clear_status", ADDR_STATUS, 32'd0);
        read_check("clear_count", ADDR_COUNT, 32'd0);
        check_meas("clear", 32'd0, 32'd0, 1'b0);
        tick(23);
        pwm_in = 1'b0;
        tick(70);
        pulse(30, 70);
        check("clear_rise_ignored", 32'(valid), 32'd0);
        pulse(30, 70);
        check_meas("after_clear", 32'd100, 32'd30, 1'b1);
        read_check("after_clear_count", ADDR_COUNT, 32'd1);

        // 5: disable mid-LOW, then re-enable
        avm_write(ADDR_CONTROL, 32'd0);
        check_meas("disable", 32'd100, 32'd30, 1'b0);
        read_check("disable_status", ADDR_STATUS, 32'd0);
        read_check("disable_control", ADDR_CONTROL, 32'd0);
        pulse(30, 70);
        check_meas("disabled_edges", 32'd100, 32'd30, 1'b0);
        avm_write(ADDR_CONTROL, 32'd1);
        pulse(20, 60);
        check_meas("reenable_first", 32'd100, 32'd30, 1'b0);
        pulse(20, 60);
        check_meas("reenable_second", 32'd80, 32'd20, 1'b1);
        read_check("reenable_control", ADDR_CONTROL, 32'd1);

        // 6: high-time sweep in a 2000-cycle period, then a 1-cycle glitch low
        pulse(1, 1999);
        pulse(2, 1998);
        check_meas("sweep_h1", 32'd2000, 32'd1, 1'b1);
        pulse(1000, 1000);
        check_meas("sweep_h2", 32'd2000, 32'd2, 1'b1);
        pwm_in = 1'b1;
        tick(5);
        check_meas("sweep_h1000", 32'd2000, 32'd1000, 1'b1);
        tick(495);
        pwm_in = 1'b0;
        tick(1);
        pwm_in = 1'b1;
        tick(5);
        check_meas("glitch_short", 32'd501, 32'd500, 1'b1);
        tick(494);
        pwm_in = 1'b0;
        tick(1000);
        pwm_in = 1'b1;
        tick(5);
        check_meas("glitch_recover", 32'd1499, 32'd499, 1'b1);
        read_check("final_count", ADDR_COUNT, 32'd8);
        read_check("final_status", ADDR_STATUS, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
